// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Imported by the arbiter, its round-robin picker and the bench.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// AXI4-Stream bundle: NUM_SRC request streams in, one stream out.
// master drives sources and sink ready; slave is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8
);

    logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]            s_axis_tvalid;
    logic [NUM_SRC-1:0]            s_axis_tlast;
    logic [NUM_SRC-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after ptr,
// wrapping modulo NUM_SRC.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int IW      = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      pick,
    output logic               any
);

    int slot;

    // Scan farthest first so the nearest requester is written last.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        slot = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            slot = int'(ptr) + k;
            if (slot >= NUM_SRC) begin
                slot = slot - NUM_SRC;
            end
            if (req[IW'(slot)]) begin
                pick = IW'(slot);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of the UART transmitter,
// with eviction of owners that stall mid-packet.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_SRC    = 4,
    parameter  int TIMEOUT    = 1024,
    localparam int IW         = idx_w(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     bus,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_index,
    output logic                 timeout_pulse
);

    localparam int   CW    = cnt_w(TIMEOUT);
    localparam int   TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic TO_EN = (TIMEOUT != 0);

    arb_state_e state_q;
    arb_state_e state_d;
    logic [IW-1:0] gidx_q;
    logic [IW-1:0] gidx_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_d;

    logic [IW-1:0] pick;
    logic          any_req;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_valid;
    logic                  g_last;
    logic                  own;
    logic [NUM_SRC-1:0]    rdy;

    logic beat;
    logic run_end;
    logic do_grant;
    logic do_eop;
    logic do_mid;
    logic do_evict;
    logic do_count;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_split
        assign src_data[i] =
            bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_tx_arbiter_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req  (bus.s_axis_tvalid),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    // Owner pass-through; idle cycles present nothing upstream.
    always_comb begin
        own     = (state_q == ST_OWN);
        g_data  = src_data[gidx_q];
        g_valid = bus.s_axis_tvalid[gidx_q];
        g_last  = bus.s_axis_tlast[gidx_q];
        rdy     = '0;
        if (own) begin
            rdy[gidx_q] = bus.m_axis_tready;
        end
    end

    assign bus.m_axis_tdata  = g_data;
    assign bus.m_axis_tvalid = own & g_valid;
    assign bus.s_axis_tready = rdy;

    assign grant_valid = own;
    assign grant_index = gidx_q;

    always_comb begin
        beat     = own & g_valid & bus.m_axis_tready;
        run_end  = (cnt_q == CW'(TLIM));
        do_grant = ~own & any_req;
        do_eop   = beat & g_last;
        do_mid   = beat & ~g_last;
        do_evict = own & ~g_valid & TO_EN & run_end;
        do_count = own & ~g_valid & TO_EN & ~run_end;
    end

    // A uart-side stall keeps tvalid high, so it never counts.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (1'b1)
            do_grant: begin
                state_d = ST_OWN;
                gidx_d  = pick;
                cnt_d   = '0;
            end
            do_eop: begin
                state_d = ST_IDLE;
                ptr_d   = gidx_q;
                cnt_d   = '0;
            end
            do_mid: begin
                cnt_d = '0;
            end
            do_evict: begin
                state_d = ST_IDLE;
                ptr_d   = gidx_q;
                cnt_d   = '0;
                pulse_d = 1'b1;
            end
            do_count: begin
                cnt_d = cnt_q + CW'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gidx_q        <= '0;
            ptr_q         <= IW'(NUM_SRC - 1);
            cnt_q         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            timeout_pulse <= pulse_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (short and long timeout)
// checked every cycle against a packet-level model.
module tb_uart_tx_arbiter;

    localparam int NS   = 4;
    localparam int DW   = 8;
    localparam int TO_A = 8;
    localparam int TO_B = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus_a ();
    uart_tx_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus_b ();

    logic [NS*DW-1:0] a_tdata;
    logic [NS-1:0]    a_tvalid;
    logic [NS-1:0]    a_tlast;
    logic [NS*DW-1:0] b_tdata;
    logic [NS-1:0]    b_tvalid;
    logic [NS-1:0]    b_tlast;
    logic             mr_a;
    logic             mr_b;

    logic       gv_a, tp_a, gv_b, tp_b;
    logic [1:0] gi_a, gi_b;

    assign bus_a.s_axis_tdata  = a_tdata;
    assign bus_a.s_axis_tvalid = a_tvalid;
    assign bus_a.s_axis_tlast  = a_tlast;
    assign bus_a.m_axis_tready = mr_a;
    assign bus_b.s_axis_tdata  = b_tdata;
    assign bus_b.s_axis_tvalid = b_tvalid;
    assign bus_b.s_axis_tlast  = b_tlast;
    assign bus_b.m_axis_tready = mr_b;

    uart_tx_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS),
        .TIMEOUT    (TO_A)
    ) dut_a (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_a),
        .grant_valid   (gv_a),
        .grant_index   (gi_a),
        .timeout_pulse (tp_a)
    );

    uart_tx_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS),
        .TIMEOUT    (TO_B)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_b),
        .grant_valid   (gv_b),
        .grant_index   (gi_b),
        .timeout_pulse (tp_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t",
                     name, idx, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name, input logic [7:0] got[$],
                             input int n, input logic [63:0] exp);
        check({name, "_len"}, 0, 32'(got.size()), 32'(n));
        for (int j = 0; j < n; j++) begin
            if (j < got.size()) begin
                check(name, j, 32'(got[j]), 32'(exp[(n-1-j)*8 +: 8]));
            end
        end
    endtask

    // Source streams for dut_a: {gap cycles before presenting, last, data}.
    logic [16:0]   srcq [NS][$];
    logic [NS-1:0] fire = '0;

    task automatic push(input int s, input logic [7:0] d,
                        input logic l, input int gap);
        srcq[s].push_back({8'(gap), l, d});
    endtask

    initial begin
        logic [16:0] e;
        a_tvalid = '0;
        a_tlast  = '0;
        a_tdata  = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NS; i++) begin
                if (fire[i] && srcq[i].size() > 0) begin
                    void'(srcq[i].pop_front());
                end
            end
            #2;
            for (int i = 0; i < NS; i++) begin
                a_tvalid[i] = 1'b0;
                a_tlast[i]  = 1'b0;
                if (srcq[i].size() > 0) begin
                    e = srcq[i][0];
                    if (e[16:9] != 8'd0) begin
                        e[16:9]   = e[16:9] - 8'd1;
                        srcq[i][0] = e;
                    end else begin
                        a_tvalid[i]          = 1'b1;
                        a_tlast[i]           = e[8];
                        a_tdata[i*DW +: DW]  = e[7:0];
                    end
                end
            end
        end
    end

    // Packet-level model: who owns the stream, whose turn is next,
    // and how long the owner has gone quiet.
    bit m_live [2];
    bit m_own  [2];
    bit m_tp   [2];
    int m_g    [2];
    int m_last [2];
    int m_quiet[2];

    task automatic model_step(
        input int k, input int tmo,
        input logic [NS-1:0] tv, input logic [NS-1:0] tl,
        input logic [NS*DW-1:0] td, input logic mr,
        input logic o_gv, input logic [1:0] o_gi, input logic o_tp,
        input logic o_mv, input logic [DW-1:0] o_md,
        input logic [NS-1:0] o_rdy);
        int g;
        int cand;
        bit found;
        logic [NS-1:0] e_rdy;
        g = m_g[k];
        if (m_live[k]) begin
            e_rdy = '0;
            if (m_own[k]) e_rdy[g] = mr;
            check("grant_valid", k, 32'(o_gv), 32'(m_own[k]));
            check("grant_index", k, 32'(o_gi), 32'(g));
            check("timeout_pulse", k, 32'(o_tp), 32'(m_tp[k]));
            check("m_tvalid", k, 32'(o_mv), 32'(m_own[k] && tv[g]));
            check("s_tready", k, 32'(o_rdy), 32'(e_rdy));
            if (m_own[k] && tv[g]) begin
                check("m_tdata", k, 32'(o_md), 32'(td[g*DW +: DW]));
            end
        end
        m_tp[k] = 1'b0;
        if (rst) begin
            m_live[k]  = 1'b1;
            m_own[k]   = 1'b0;
            m_g[k]     = 0;
            m_last[k]  = NS - 1;
            m_quiet[k] = 0;
        end else if (!m_live[k]) begin
            m_live[k] = 1'b0;
        end else if (!m_own[k]) begin
            found = 1'b0;
            for (int j = 1; j <= NS; j++) begin
                cand = (m_last[k] + j) % NS;
                if (!found && tv[cand]) begin
                    found      = 1'b1;
                    m_g[k]     = cand;
                    m_own[k]   = 1'b1;
                    m_quiet[k] = 0;
                end
            end
        end else if (tv[g]) begin
            if (mr) begin
                m_quiet[k] = 0;
                if (tl[g]) begin
                    m_own[k]  = 1'b0;
                    m_last[k] = g;
                end
            end
        end else if (tmo != 0) begin
            m_quiet[k] = m_quiet[k] + 1;
            if (m_quiet[k] == tmo) begin
                m_own[k]   = 1'b0;
                m_last[k]  = g;
                m_tp[k]    = 1'b1;
                m_quiet[k] = 0;
            end
        end
    endtask

    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    logic [7:0] gq[$];
    int np_a = 0;
    int np_b = 0;

    initial begin
        logic gv_a_d;
        gv_a_d = 1'b0;
        forever begin
            @(negedge clk);
            model_step(0, TO_A, a_tvalid, a_tlast, a_tdata, mr_a,
                       gv_a, gi_a, tp_a, bus_a.m_axis_tvalid,
                       bus_a.m_axis_tdata, bus_a.s_axis_tready);
            model_step(1, TO_B, b_tvalid, b_tlast, b_tdata, mr_b,
                       gv_b, gi_b, tp_b, bus_b.m_axis_tvalid,
                       bus_b.m_axis_tdata, bus_b.s_axis_tready);
            fire = a_tvalid & bus_a.s_axis_tready;
            if (bus_a.m_axis_tvalid && mr_a) rx_a.push_back(bus_a.m_axis_tdata);
            if (bus_b.m_axis_tvalid && mr_b) rx_b.push_back(bus_b.m_axis_tdata);
            if (gv_a && !gv_a_d) gq.push_back(8'(gi_a));
            gv_a_d = gv_a;
            if (tp_a) np_a++;
            if (tp_b) np_b++;
        end
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drv();
    endtask

    task automatic clear_logs();
        rx_a.delete();
        rx_b.delete();
        gq.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mr_a     = 1'b1;
        mr_b     = 1'b1;
        b_tvalid = '0;
        b_tlast  = '0;
        b_tdata  = '0;
        repeat (3) @(posedge clk);
        smp();
        check("rst_gv", 0, 32'(gv_a), 32'h0);
        check("rst_gi", 0, 32'(gi_a), 32'h0);
        check("rst_tp", 0, 32'(tp_a), 32'h0);
        check("rst_mv", 0, 32'(bus_a.m_axis_tvalid), 32'h0);
        check("rst_rdy", 0, 32'(bus_a.s_axis_tready), 32'h0);

        // src0 alone, uart always ready
        drv();
        rst = 1'b0;
        push(0, 8'h41, 1'b0, 0);
        push(0, 8'h42, 1'b0, 0);
        push(0, 8'h43, 1'b1, 0);
        smp();
        check("t1_c0_gv", 0, 32'(gv_a), 32'h0);
        for (int j = 0; j < 3; j++) begin
            smp();
            check("t1_gv", j, 32'(gv_a), 32'h1);
            check("t1_mv", j, 32'(bus_a.m_axis_tvalid), 32'h1);
            check("t1_data", j, 32'(bus_a.m_axis_tdata), 32'(8'h41 + j));
        end
        smp();
        check("t1_end_gv", 0, 32'(gv_a), 32'h0);
        idle(4);
        check_seq("t1_rx", rx_a, 3, 64'h41_42_43);
        clear_logs();

        // src1 and src3 together
        push(1, 8'h11, 1'b0, 0);
        push(1, 8'h12, 1'b1, 0);
        push(3, 8'h31, 1'b0, 0);
        push(3, 8'h32, 1'b1, 0);
        idle(10);
        check_seq("t2_grants", gq, 2, 64'h01_03);
        check_seq("t2_rx", rx_a, 4, 64'h11_12_31_32);
        clear_logs();

        // src0 and src2 streaming single-byte packets
        for (int n = 0; n < 4; n++) begin
            push(2, 8'(8'h21 + n), 1'b1, 0);
            push(0, 8'(8'h01 + n), 1'b1, 0);
        end
        idle(20);
        check_seq("t3_grants", gq, 8, 64'h00_02_00_02_00_02_00_02);
        check_seq("t3_rx", rx_a, 8, 64'h01_21_02_22_03_23_04_24);
        clear_logs();

        // src0 goes quiet for 8 cycles with src1 waiting
        push(0, 8'h51, 1'b0, 0);
        push(0, 8'h52, 1'b1, 8);
        push(1, 8'h61, 1'b1, 0);
        idle(20);
        check("t4_pulses", 0, 32'(np_a), 32'h1);
        check_seq("t4_grants", gq, 3, 64'h00_01_00);
        check_seq("t4_rx", rx_a, 3, 64'h51_61_52);
        clear_logs();

        // one cycle short of the limit: no eviction
        push(0, 8'h71, 1'b0, 0);
        push(0, 8'h72, 1'b1, 7);
        idle(20);
        check("t4b_pulses", 0, 32'(np_a), 32'h1);
        check_seq("t4b_grants", gq, 1, 64'h00);
        check_seq("t4b_rx", rx_a, 2, 64'h71_72);
        clear_logs();

        // long uart stall on both instances
        mr_a = 1'b0;
        mr_b = 1'b0;
        push(3, 8'h81, 1'b0, 0);
        push(3, 8'h82, 1'b1, 0);
        b_tvalid[1]     = 1'b1;
        b_tlast[1]      = 1'b0;
        b_tdata[15:8]   = 8'h5A;
        idle(2000);
        smp();
        check("t5_gv_b", 0, 32'(gv_b), 32'h1);
        check("t5_gi_b", 0, 32'(gi_b), 32'h1);
        check("t5_gv_a", 0, 32'(gv_a), 32'h1);
        drv();
        mr_a = 1'b1;
        mr_b = 1'b1;
        drv();
        b_tdata[15:8] = 8'h5B;
        b_tlast[1]    = 1'b1;
        drv();
        b_tvalid = '0;
        b_tlast  = '0;
        idle(6);
        check("t5_pulses_b", 0, 32'(np_b), 32'h0);
        check("t5_pulses_a", 0, 32'(np_a), 32'h1);
        check_seq("t5_rx_b", rx_b, 2, 64'h5A_5B);
        check_seq("t5_rx_a", rx_a, 2, 64'h81_82);
        clear_logs();

        // reset in the middle of a src2 packet
        push(2, 8'h91, 1'b0, 0);
        push(2, 8'h92, 1'b0, 0);
        push(2, 8'h93, 1'b1, 0);
        push(0, 8'hA1, 1'b1, 2);
        drv();
        rst = 1'b1;
        drv();
        rst = 1'b0;
        smp();
        check("t6_gv", 0, 32'(gv_a), 32'h0);
        check("t6_mv", 0, 32'(bus_a.m_axis_tvalid), 32'h0);
        check("t6_gi", 0, 32'(gi_a), 32'h0);
        idle(12);
        check_seq("t6_grants", gq, 3, 64'h02_00_02);
        check_seq("t6_rx", rx_a, 4, 64'h91_A1_92_93);
        check("t6_drained", 0,
              32'(srcq[0].size() + srcq[1].size() +
                  srcq[2].size() + srcq[3].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
